// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers feeding rename, compacted alloc/release.
// Optional FREELIST_CHECK_EN adds a sticky fl_err output and drops overflowing releases.
module free_list #(
    parameter int ARF_WIDTH  = 5,
    parameter int PRF_WIDTH  = 6,
    parameter int DECODE_NUM = 4,
    parameter int RETIRE_NUM = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DECODE_NUM-1:0]           alloc_v,
    output logic [DECODE_NUM*PRF_WIDTH-1:0] alloc_prd,
    output logic                            alloc_ok,
    input  logic [RETIRE_NUM-1:0]           retire,
    input  logic [RETIRE_NUM-1:0]           rob_areg_v,
    input  logic [RETIRE_NUM*PRF_WIDTH-1:0] rob_opreg,
`ifdef FREELIST_CHECK_EN
    output logic                            fl_err,
`endif
    output logic [PRF_WIDTH:0]              free_cnt
);
    localparam int FL_DEPTH = (1 << PRF_WIDTH) - (1 << ARF_WIDTH);
    localparam int PW = $clog2(FL_DEPTH);
    localparam int CW = PRF_WIDTH + 1;
    localparam logic [PW:0] DEPTH_P = (PW+1)'(FL_DEPTH);

    logic [PRF_WIDTH-1:0] fl_q [FL_DEPTH];
    logic [PW-1:0]        head_q, tail_q;
    logic [CW-1:0]        count_q, count_d, need, rel_n, tail_n;
    logic [PW-1:0]        a_idx [DECODE_NUM];
    logic [PW-1:0]        r_idx [RETIRE_NUM];
    logic [RETIRE_NUM-1:0] rel, rel_w;
`ifdef FREELIST_CHECK_EN
    logic fl_err_q, ovf, dup;
    assign fl_err = fl_err_q;
`endif

    function automatic logic [PW-1:0] wrap(input logic [PW:0] x);
        logic [PW:0] y;
        y = (x >= DEPTH_P) ? x - DEPTH_P : x;
        return y[PW-1:0];
    endfunction

    assign free_cnt = count_q;

    // Slot k reads the entry offset by the number of requesting slots below it.
    always_comb begin
        need      = '0;
        alloc_prd = '0;
        for (int k = 0; k < DECODE_NUM; k++) begin
            a_idx[k] = wrap({1'b0, head_q} + need[PW:0]);
            need     = need + CW'(alloc_v[k]);
        end
        alloc_ok = count_q >= need;
        for (int k = 0; k < DECODE_NUM; k++)
            alloc_prd[k*PRF_WIDTH +: PRF_WIDTH] = (alloc_ok && alloc_v[k]) ? fl_q[a_idx[k]] : '0;
    end

    // x0 is identity-mapped forever, so a retiring P0 is never returned.
    always_comb begin
        rel_n = '0;
        for (int k = 0; k < RETIRE_NUM; k++) begin
            rel[k]   = retire[k] && rob_areg_v[k] && (rob_opreg[k*PRF_WIDTH +: PRF_WIDTH] != '0);
            r_idx[k] = wrap({1'b0, tail_q} + rel_n[PW:0]);
            rel_n    = rel_n + CW'(rel[k]);
        end
        count_d = count_q - (alloc_ok ? need : '0) + rel_n;
        rel_w   = rel;
        tail_n  = rel_n;
`ifdef FREELIST_CHECK_EN
        ovf = count_d > CW'(FL_DEPTH);
        dup = 1'b0;
        for (int k = 0; k < RETIRE_NUM; k++)
            for (int j = 0; j < DECODE_NUM; j++)
                dup = dup | (rel[k] && alloc_ok && alloc_v[j] &&
                      rob_opreg[k*PRF_WIDTH +: PRF_WIDTH] == alloc_prd[j*PRF_WIDTH +: PRF_WIDTH]);
        rel_w   = ovf ? '0 : rel;
        tail_n  = ovf ? '0 : rel_n;
        count_d = ovf ? count_q - (alloc_ok ? need : '0) : count_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++)
                fl_q[i] <= PRF_WIDTH'((1 << ARF_WIDTH) + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(FL_DEPTH);
`ifdef FREELIST_CHECK_EN
            fl_err_q <= 1'b0;
`endif
        end else begin
            if (alloc_ok)
                head_q <= wrap({1'b0, head_q} + need[PW:0]);
            tail_q  <= wrap({1'b0, tail_q} + tail_n[PW:0]);
            count_q <= count_d;
            for (int k = 0; k < RETIRE_NUM; k++)
                if (rel_w[k])
                    fl_q[r_idx[k]] <= rob_opreg[k*PRF_WIDTH +: PRF_WIDTH];
`ifdef FREELIST_CHECK_EN
            fl_err_q <= fl_err_q | ovf | dup;
`endif
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: queue-based reference model compared every cycle, plus hand-computed checkpoints.
module tb_free_list;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  alloc_v = '0, retire = '0, rob_areg_v = '0;
    logic [23:0] rob_opreg = '0, alloc_prd;
    logic        alloc_ok;
    logic [6:0]  free_cnt;
`ifdef FREELIST_CHECK_EN
    logic        fl_err;
`endif
    int total = 0, bad = 0;

    free_list dut (
        .clk(clk), .rst_n(rst_n), .alloc_v(alloc_v), .alloc_prd(alloc_prd), .alloc_ok(alloc_ok),
        .retire(retire), .rob_areg_v(rob_areg_v), .rob_opreg(rob_opreg),
`ifdef FREELIST_CHECK_EN
        .fl_err(fl_err),
`endif
        .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pk(input int s0, input int s1, input int s2, input int s3);
        logic [5:0] a, b, c, d;
        a = 6'(s0); b = 6'(s1); c = 6'(s2); d = 6'(s3);
        return {d, c, b, a};
    endfunction

    // Reference model: the free list is just an ordered queue of register numbers.
    int m_q[$];
    bit m_err;
    int m_need, m_o, m_rel[$], m_got[$];
    bit m_ok;
    logic [23:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = {};
            for (int i = 0; i < 32; i++) m_q.push_back(32 + i);
            m_err = 0;
        end else begin
            m_need = $countones(alloc_v);
            m_ok = m_q.size() >= m_need;
            m_got = {};
            m_rel = {};
            if (m_ok)
                for (int k = 0; k < m_need; k++) m_got.push_back(m_q.pop_front());
            for (int k = 0; k < 4; k++)
                if (retire[k] && rob_areg_v[k] && rob_opreg[k*6 +: 6] != 0)
                    m_rel.push_back(int'(rob_opreg[k*6 +: 6]));
`ifdef FREELIST_CHECK_EN
            foreach (m_rel[r]) foreach (m_got[g]) if (m_rel[r] == m_got[g]) m_err = 1;
            if (m_q.size() + m_rel.size() > 32) begin
                m_err = 1;
                m_rel = {};
            end
`endif
            foreach (m_rel[r]) m_q.push_back(m_rel[r]);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            m_need = $countones(alloc_v);
            m_ok = m_q.size() >= m_need;
            m_exp = '0;
            m_o = 0;
            for (int k = 0; k < 4; k++)
                if (alloc_v[k]) begin
                    if (m_ok) m_exp[k*6 +: 6] = 6'(m_q[m_o]);
                    m_o++;
                end
            chk("alloc_ok", 32'(alloc_ok), 32'(m_ok));
            chk("alloc_prd", 32'(alloc_prd), 32'(m_exp));
            chk("free_cnt", 32'(free_cnt), 32'(m_q.size()));
`ifdef FREELIST_CHECK_EN
            chk("fl_err", 32'(fl_err), 32'(m_err));
`endif
        end
    end

    task automatic drive(input logic [3:0] av, input logic [3:0] rt, input logic [3:0] ar,
                         input logic [23:0] op);
        @(posedge clk);
        #1;
        alloc_v = av; retire = rt; rob_areg_v = ar; rob_opreg = op;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        alloc_v = '0; retire = '0; rob_areg_v = '0; rob_opreg = '0;
        @(negedge clk);
        chk("lit_rst_cnt", 32'(free_cnt), 32);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [23:0] op;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_init_cnt", 32'(free_cnt), 32);
        chk("lit_init_ok", 32'(alloc_ok), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b1111, 0, 0, 0);
        chk("lit_t1_prd", 32'(alloc_prd), 32'(pk(32, 33, 34, 35)));
        chk("lit_t1_ok", 32'(alloc_ok), 1);
        drive(0, 0, 0, 0);
        chk("lit_t1_cnt", 32'(free_cnt), 28);
        reset_pulse();
        drive(4'b1010, 0, 0, 0);
        chk("lit_t2_prd", 32'(alloc_prd), 32'(pk(0, 32, 0, 33)));
        drive(0, 0, 0, 0);
        chk("lit_t2_cnt", 32'(free_cnt), 30);
        reset_pulse();
        repeat (8) drive(4'b1111, 0, 0, 0);
        drive(4'b0001, 0, 0, 0);
        chk("lit_t3_ok", 32'(alloc_ok), 0);
        chk("lit_t3_prd", 32'(alloc_prd), 0);
        chk("lit_t3_cnt", 32'(free_cnt), 0);
        drive(0, 4'b1111, 4'b0101, pk(5, 7, 9, 0));
        drive(4'b0011, 0, 0, 0);
        chk("lit_t4_cnt", 32'(free_cnt), 2);
        chk("lit_t4_prd", 32'(alloc_prd), 32'(pk(5, 9, 0, 0)));
        drive(0, 4'b0011, 4'b0011, pk(12, 13, 0, 0));
        drive(4'b1111, 4'b0111, 4'b1111, pk(14, 15, 16, 17));
        chk("lit_t5_ok0", 32'(alloc_ok), 0);
        chk("lit_t5_prd0", 32'(alloc_prd), 0);
        drive(4'b1111, 0, 0, 0);
        chk("lit_t5_cnt", 32'(free_cnt), 5);
        chk("lit_t5_ok1", 32'(alloc_ok), 1);
        chk("lit_t5_prd1", 32'(alloc_prd), 32'(pk(12, 13, 14, 15)));
        drive(0, 4'b1111, 4'b1111, pk(20, 0, 21, 0));
        drive(0, 4'b1111, 4'b1111, pk(22, 23, 24, 25));
        chk("lit_x0_cnt", 32'(free_cnt), 3);
        drive(0, 4'b1111, 4'b1111, pk(26, 27, 28, 29));
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 4; j++) op[j*6 +: 6] = 6'(1 + (4*i + j) % 31);
            drive(4'b1111, 4'b1111, 4'b1111, op);
        end
        drive(0, 0, 0, 0);
        chk("lit_t6_cnt", 32'(free_cnt), 11);
`ifdef FREELIST_CHECK_EN
        reset_pulse();
        drive(0, 4'b0001, 4'b0001, pk(7, 0, 0, 0));
        chk("lit_ck_err0", 32'(fl_err), 0);
        drive(0, 0, 0, 0);
        chk("lit_ck_err1", 32'(fl_err), 1);
        chk("lit_ck_cnt", 32'(free_cnt), 32);
        drive(0, 0, 0, 0);
        chk("lit_ck_sticky", 32'(fl_err), 1);
        reset_pulse();
        drive(4'b0001, 4'b0001, 4'b0001, pk(32, 0, 0, 0));
        chk("lit_ck_dup_prd", 32'(alloc_prd), 32);
        drive(0, 0, 0, 0);
        chk("lit_ck_dup_err", 32'(fl_err), 1);
`endif
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
